// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle main control FSM.
// The ALU class codes are consumed by the downstream ALU control decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WR   = 4'd4,
    MEM_WB   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that issue a memory request and may stall on mem_ready.
  function automatic logic is_mem_state(input mc_state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_main_control_mem_watchdog.sv
// Memory wait counter with timeout compare; start clears the count,
// otherwise it counts stalled cycles and saturates at MEM_TIMEOUT.
module mc_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic             ENABLE = (MEM_TIMEOUT != 0);

  logic [CNT_W-1:0] wait_cnt;
  logic             stalled;

  assign stalled = waiting & ~mem_ready;
  assign timeout = ENABLE & stalled & (wait_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (stalled && (wait_cnt != LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS-subset main control: Moore decode of datapath controls,
// with memory-handshake signals qualified by mem_ready and the watchdog.
module mc_main_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);

  mc_state_e state, state_next;
  logic      timeout;
  logic      wd_start;

  // The counter restarts whenever a memory state is entered, including the
  // FETCH -> FETCH retry after a timeout.
  assign wd_start = is_mem_state(state_next) && ((state_next != state) || timeout);

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (wd_start),
    .waiting  (is_mem_state(state)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Handshake: a request (mem_read/mem_write) is held until the cycle in
  // which mem_ready is high; that cycle completes the access. A timeout only
  // fires with mem_ready low, so a late ready always wins.
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_FUNCT;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;

    unique case (state)
      FETCH: begin
        mem_read  = ~timeout;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_next = DECODE;
        else if (timeout) begin
          mem_timeout = 1'b1;
          state_next  = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALUOP_ADD;
        unique case (opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_RTYPE:     state_next = R_EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = I_EXEC;
          OP_J:         state_next = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = ~timeout;
        iord     = 1'b1;
        if (mem_ready)    state_next = MEM_WB;
        else if (timeout) begin
          mem_timeout = 1'b1;
          state_next  = FETCH;
        end
      end
      MEM_WR: begin
        mem_write = ~timeout;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = FETCH;
        end else if (timeout) begin
          mem_timeout = 1'b1;
          state_next  = FETCH;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_next    = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Outputs are held low for the whole reset assertion, not just at the edge.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
    end
  end

  assign state_dbg = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: reset, latencies, memory stalls,
// watchdog aborts, illegal opcodes and reset during writeback.
module tb_mc_main_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op, mem_timeout;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  mc_main_control #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [22:0] all_out;
  assign all_out = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, instr_done, illegal_op, mem_timeout, state_dbg};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard: compare state_dbg against queued states, one per cycle
  task automatic drain(input string tag, output int n_done, output int done_at);
    logic [3:0] e;
    int i;
    n_done  = 0;
    done_at = 0;
    i       = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i++;
      chk(tag, 32'(state_dbg), 32'(e));
      if (instr_done) begin
        n_done++;
        done_at = i;
      end
      tick();
    end
  endtask

  initial begin
    int n_done, done_at, wr_cycles;

    // 1. reset
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_RTYPE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", 32'(all_out), 32'd0);
    end
    rst_n = 1'b1;
    settle();
    chk("rel_mem_read", 32'(mem_read), 32'd1);
    chk("rel_ir_write", 32'(ir_write), 32'd1);
    chk("rel_pc_write", 32'(pc_write), 32'd1);
    chk("rel_alu_src_b", 32'(alu_src_b), 32'd1);
    chk("rel_alu_op", 32'(alu_op), 32'd2);

    // 2. R-type latency
    exp_q.push_back(FETCH); exp_q.push_back(DECODE);
    exp_q.push_back(R_EXEC); exp_q.push_back(R_WB);
    drain("rtype_state", n_done, done_at);
    chk("rtype_done_cnt", 32'(n_done), 32'd1);
    chk("rtype_done_at", 32'(done_at), 32'd4);
    chk("rtype_back_fetch", 32'(state_dbg), 32'd0);

    // lw latency
    opcode = OP_LW;
    exp_q.push_back(FETCH); exp_q.push_back(DECODE);
    exp_q.push_back(MEM_ADDR); exp_q.push_back(MEM_RD);
    drain("lw_state", n_done, done_at);
    chk("lw_no_early_done", 32'(n_done), 32'd0);
    chk("lw_wb_state", 32'(state_dbg), 32'd5);
    chk("lw_wb_done", 32'(instr_done), 32'd1);
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_reg_write", 32'(reg_write), 32'd1);
    chk("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
    tick();

    // 3. sw with three stalled cycles in MEM_WR
    opcode = OP_SW;
    exp_q.push_back(FETCH); exp_q.push_back(DECODE); exp_q.push_back(MEM_ADDR);
    drain("sw_state", n_done, done_at);
    chk("sw_no_early_done", 32'(n_done), 32'd0);
    mem_ready = 1'b0;
    settle();
    wr_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", 32'(state_dbg), 32'd4);
      chk("sw_wait_done", 32'(instr_done), 32'd0);
      if (mem_write) wr_cycles++;
      tick();
    end
    mem_ready = 1'b1;
    settle();
    if (mem_write) wr_cycles++;
    chk("sw_ready_done", 32'(instr_done), 32'd1);
    chk("sw_iord", 32'(iord), 32'd1);
    chk("sw_write_cycles", 32'(wr_cycles), 32'd4);
    tick();
    chk("sw_back_fetch", 32'(state_dbg), 32'd0);

    // 4. fetch timeout (MEM_TIMEOUT = 4)
    mem_ready = 1'b0;
    opcode    = OP_J;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("fto_wait_read", 32'(mem_read), 32'd1);
      chk("fto_wait_to", 32'(mem_timeout), 32'd0);
      chk("fto_wait_pcw", 32'(pc_write), 32'd0);
      tick();
    end
    chk("fto_pulse", 32'(mem_timeout), 32'd1);
    chk("fto_req_drop", 32'(mem_read), 32'd0);
    chk("fto_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("fto_refetch_state", 32'(state_dbg), 32'd0);
    chk("fto_refetch_read", 32'(mem_read), 32'd1);
    chk("fto_single_pulse", 32'(mem_timeout), 32'd0);
    mem_ready = 1'b1;
    settle();
    chk("fto_ready_pcw", 32'(pc_write), 32'd1);
    tick();
    chk("j_decode", 32'(state_dbg), 32'd1);
    tick();
    chk("j_state", 32'(state_dbg), 32'd11);
    chk("j_pcw", 32'(pc_write), 32'd1);
    chk("j_pcsrc", 32'(pc_source), 32'd2);
    chk("j_done", 32'(instr_done), 32'd1);
    tick();

    // 5. illegal opcode then beq
    opcode = 6'b111111;
    tick();
    chk("ill_state", 32'(state_dbg), 32'd1);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_no_done", 32'(instr_done), 32'd0);
    tick();
    chk("ill_to_fetch", 32'(state_dbg), 32'd0);
    chk("ill_single", 32'(illegal_op), 32'd0);
    opcode = OP_BEQ;
    tick();
    tick();
    chk("beq_state", 32'(state_dbg), 32'd10);
    chk("beq_pcwc", 32'(pc_write_cond), 32'd1);
    chk("beq_alu_op", 32'(alu_op), 32'd1);
    chk("beq_pcsrc", 32'(pc_source), 32'd1);
    chk("beq_done", 32'(instr_done), 32'd1);
    tick();

    // lw aborted by a read timeout in MEM_RD
    opcode = OP_LW;
    tick(); tick(); tick();
    chk("rto_state", 32'(state_dbg), 32'd3);
    mem_ready = 1'b0;
    settle();
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (instr_done || reg_write || mem_timeout) n_done++;
      tick();
    end
    chk("rto_no_early", 32'(n_done), 32'd0);
    chk("rto_pulse", 32'(mem_timeout), 32'd1);
    chk("rto_read_drop", 32'(mem_read), 32'd0);
    tick();
    chk("rto_to_fetch", 32'(state_dbg), 32'd0);
    chk("rto_no_done", 32'(instr_done), 32'd0);
    mem_ready = 1'b1;
    settle();

    // 6. reset during MEM_WB of lw
    tick(); tick(); tick(); tick();
    chk("mid_wb_state", 32'(state_dbg), 32'd5);
    chk("mid_wb_rw", 32'(reg_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rw", 32'(reg_write), 32'd0);
    chk("mid_rst_done", 32'(instr_done), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("mid_rel_state", 32'(state_dbg), 32'd0);
    chk("mid_rel_read", 32'(mem_read), 32'd1);
    chk("mid_rel_done", 32'(instr_done), 32'd0);
    tick();
    chk("mid_rel_decode", 32'(state_dbg), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
